ram_arbiter: RTL and testbench

Shares the single data RAM port between the core load/store path and the UART sender's word-fetch path. The core path passes through combinationally, preserving single-cycle execution. The UART fetch path uses a request/acknowledge handshake and is served in cycles where the core does not touch memory. The block sits between `core` load/store signals, the UART fetch logic and `ram`.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arb_starve_cnt.sv | 28 ++
 rtl/ram_arbiter.sv | 102 ++++++++++
 tb/tb_ram_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and sizing helpers for the RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_e;

    localparam int RAM_ARB_MAX_WAIT_DEF = 15;

    // Width needed to hold 0..max_wait; never narrower than one bit.
    function automatic int cnt_w(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/ram_arb_starve_cnt.sv
// Saturating starvation counter: clear wins over increment, holds at MAX_WAIT.
module ram_arb_starve_cnt
    import ram_arb_pkg::*;
#(
    parameter int MAX_WAIT = RAM_ARB_MAX_WAIT_DEF,
    parameter int CW       = cnt_w(MAX_WAIT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic          at_max,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    assign at_max = (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the core load/store path and the UART word fetch.
// Define RAM_ARB_FAIRNESS_EN to bound UART starvation with a forced, core-stalling grant.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = RAM_ARB_MAX_WAIT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [DATA_W-1:0] i_c_wdata,
    input  logic              i_c_read_en,
    input  logic              i_c_write_en,
    output logic [DATA_W-1:0] o_c_rdata,
    output logic              o_c_stall,
    input  logic              i_d_req,
    input  logic [ADDR_W-1:0] i_d_addr,
    output logic              o_d_ack,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    output logic              o_m_read_en,
    output logic              o_m_write_en,
    input  logic [DATA_W-1:0] i_m_rdata
);

    arb_state_e state, state_nxt;
    logic       core_acc;
    logic       grant;
    logic       frc;

`ifdef RAM_ARB_FAIRNESS_EN
    localparam int CW = cnt_w(MAX_WAIT);
    logic          at_max;
    logic [CW-1:0] wait_cnt;

    // Counter runs only while a request keeps waiting; any exit from WAIT clears it.
    ram_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (CW)
    ) u_starve_cnt (
        .clk    (i_clk),
        .rst    (i_rst),
        .clr    (state_nxt != ST_WAIT),
        .inc    ((state == ST_WAIT) && (state_nxt == ST_WAIT)),
        .at_max (at_max),
        .cnt    (wait_cnt)
    );

    assign frc       = (state == ST_WAIT) && at_max;
    assign o_c_stall = grant && frc;
`else
    assign frc       = 1'b0;
    assign o_c_stall = 1'b0;
`endif

    assign core_acc  = i_c_read_en | i_c_write_en;
    assign grant     = i_d_req && (state != ST_ACK) && (!core_acc || frc);
    assign o_c_rdata = i_m_rdata;
    assign o_d_ack   = (state == ST_ACK);

    always_comb begin
        o_m_addr     = i_c_addr;
        o_m_wdata    = i_c_wdata;
        o_m_read_en  = i_c_read_en;
        o_m_write_en = i_c_write_en;
        if (grant) begin
            o_m_addr     = i_d_addr;
            o_m_read_en  = 1'b1;
            o_m_write_en = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant)        state_nxt = ST_ACK;
                else if (i_d_req) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (grant)         state_nxt = ST_ACK;
                else if (!i_d_req) state_nxt = ST_IDLE;
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            o_d_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant) o_d_rdata <= i_m_rdata;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: ack data/timing checked by a scoreboard monitor.
module tb_ram_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_c_addr, i_c_wdata, i_d_addr, i_m_rdata;
    logic        i_c_read_en, i_c_write_en, i_d_req;
    logic [31:0] o_c_rdata, o_d_rdata, o_m_addr, o_m_wdata;
    logic        o_c_stall, o_d_ack, o_m_read_en, o_m_write_en;

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_c_addr(i_c_addr), .i_c_wdata(i_c_wdata),
        .i_c_read_en(i_c_read_en), .i_c_write_en(i_c_write_en),
        .o_c_rdata(o_c_rdata), .o_c_stall(o_c_stall),
        .i_d_req(i_d_req), .i_d_addr(i_d_addr),
        .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata),
        .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata),
        .o_m_read_en(o_m_read_en), .o_m_write_en(o_m_write_en),
        .i_m_rdata(i_m_rdata)
    );

    always #5 i_clk = ~i_clk;

    // RAM model: 256 words, combinational read, unwritten words have a fixed pattern.
    logic [31:0]  mem [0:255];
    logic [255:0] wr_vld = '0;

    function automatic logic [31:0] dflt(input logic [7:0] a);
        return (a == 8'h40) ? 32'hDEADBEEF : {24'hA5A5A5, a};
    endfunction

    always_comb i_m_rdata = wr_vld[o_m_addr[7:0]] ? mem[o_m_addr[7:0]] : dflt(o_m_addr[7:0]);

    always @(posedge i_clk) begin
        if (o_m_write_en) begin
            mem[o_m_addr[7:0]]    <= o_m_wdata;
            wr_vld[o_m_addr[7:0]] <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_ack  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        else n_pass++;
    endtask

    task automatic push(input int c, input logic [31:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: every ack must match the oldest expectation in cycle and data.
    always @(negedge i_clk) begin
        if (o_d_ack === 1'b1) begin
            exp_t e;
            n_ack++;
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("ack_data", o_d_rdata, e.data);
            end
        end
    end

    task automatic cyc_start();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    task automatic core_idle();
        i_c_read_en  = 1'b0;
        i_c_write_en = 1'b0;
    endtask

    initial begin
        int acks_before;
        logic bad_stall;
        i_rst = 1'b1; i_d_req = 1'b0; i_d_addr = '0;
        i_c_addr = 32'h55; i_c_wdata = '0;
        core_idle();

        // reset state
        cyc_start(); cyc_start(); mid();
        chk("rst_m_addr", o_m_addr, 32'h55);
        chk("rst_ack", 32'(o_d_ack), 0);
        chk("rst_rdata", o_d_rdata, 0);
        chk("rst_stall", 32'(o_c_stall), 0);
        cyc_start(); i_rst = 1'b0; i_c_addr = '0; mid();

        // core idle fetch: grant in cycle 0, ack in cycle 1
        cyc_start(); i_d_req = 1'b1; i_d_addr = 32'h40; push(cyc + 1, 32'hDEADBEEF); mid();
        chk("fetch_m_addr", o_m_addr, 32'h40);
        chk("fetch_rd_en", 32'(o_m_read_en), 1);
        chk("fetch_wr_en", 32'(o_m_write_en), 0);
        cyc_start(); i_d_req = 1'b0; mid();
        cyc_start(); mid();
        chk("ack_one_cycle", 32'(o_d_ack), 0);

        // core store beats a pending request, grant once the core goes idle
        cyc_start();
        i_c_write_en = 1'b1; i_c_addr = 32'h10; i_c_wdata = 32'h1234;
        i_d_req = 1'b1; i_d_addr = 32'h20;
        mid();
        chk("store_m_addr", o_m_addr, 32'h10);
        chk("store_wr_en", 32'(o_m_write_en), 1);
        chk("store_wdata", o_m_wdata, 32'h1234);
        cyc_start(); core_idle(); push(cyc + 1, 32'hA5A5A520); mid();
        chk("wait_grant_addr", o_m_addr, 32'h20);
        cyc_start(); i_d_req = 1'b0; mid();
        cyc_start(); mid();

        // request withdrawn from WAIT: back to IDLE, no ack
        cyc_start(); i_c_read_en = 1'b1; i_c_addr = 32'h40; i_d_req = 1'b1; i_d_addr = 32'h20; mid();
        chk("core_rdata", o_c_rdata, 32'hDEADBEEF);
        chk("core_prio_addr", o_m_addr, 32'h40);
        cyc_start(); mid();
        cyc_start(); mid();
        cyc_start(); i_d_req = 1'b0; mid();
        cyc_start(); core_idle(); mid();
        cyc_start(); i_d_req = 1'b1; push(cyc + 1, 32'hA5A5A520); mid();
        chk("after_withdraw_grant", o_m_addr, 32'h20);
        cyc_start(); i_d_req = 1'b0; mid();

        // continuous core traffic with a held request
        cyc_start();
        i_c_write_en = 1'b1; i_c_addr = 32'h08; i_c_wdata = 32'h77;
        i_d_req = 1'b1; i_d_addr = 32'h30;
`ifdef RAM_ARB_FAIRNESS_EN
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc_start();
            mid();
            chk("denied_stall", 32'(o_c_stall), 0);
            chk("denied_wr_en", 32'(o_m_write_en), 1);
        end
        cyc_start(); push(cyc + 1, 32'hA5A5A530); mid();
        chk("force_stall", 32'(o_c_stall), 1);
        chk("force_wr_en", 32'(o_m_write_en), 0);
        chk("force_m_addr", o_m_addr, 32'h30);
        cyc_start(); i_d_req = 1'b0; mid();
        chk("post_force_stall", 32'(o_c_stall), 0);
        chk("post_force_addr", o_m_addr, 32'h08);
`else
        acks_before = n_ack;
        bad_stall   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) cyc_start();
            mid();
            if (o_c_stall !== 1'b0 || o_m_addr !== 32'h08) bad_stall = 1'b1;
        end
        chk("starve_no_ack", 32'(n_ack - acks_before), 0);
        chk("starve_core_path", 32'(bad_stall), 0);
        cyc_start(); i_d_req = 1'b0; mid();
`endif
        cyc_start(); core_idle(); mid();

        // reset during ACK drops the ack and clears the data
        cyc_start(); i_d_req = 1'b1; i_d_addr = 32'h40; push(cyc + 1, 32'hDEADBEEF); mid();
        cyc_start(); i_d_req = 1'b0; i_rst = 1'b1; mid();
        cyc_start(); i_rst = 1'b0; mid();
        chk("rst_ack_dropped", 32'(o_d_ack), 0);
        chk("rst_rdata_clr", o_d_rdata, 0);
        cyc_start(); i_d_req = 1'b1; i_d_addr = 32'h20; push(cyc + 1, 32'hA5A5A520); mid();
        chk("after_rst_grant", o_m_addr, 32'h20);
        cyc_start(); i_d_req = 1'b0; mid();

        // back-to-back fetches: one word every two cycles
        cyc_start();
        i_c_addr = 32'h99; i_d_req = 1'b1; i_d_addr = 32'h10;
        push(cyc + 1, 32'h1234); push(cyc + 3, 32'h1234); push(cyc + 5, 32'h1234);
        mid();
        chk("b2b_grant_addr", o_m_addr, 32'h10);
        cyc_start(); mid();
        chk("ack_no_grant_addr", o_m_addr, 32'h99);
        chk("ack_no_grant_rd", 32'(o_m_read_en), 0);
        for (int k = 0; k < 3; k++) begin
            cyc_start(); mid();
        end
        cyc_start(); i_d_req = 1'b0; mid();
        cyc_start(); mid();
        cyc_start(); mid();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
